// File: rtl/dpram_pkg.sv
// Shared constants, clear-sequencer encoding and helpers for the parametrised
// true dual-port RAM.
package dpram_pkg;

   localparam int RDW_OLD = 0;
   localparam int RDW_NEW = 1;

   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_READY = 1'b1;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result++;
      return result;
   endfunction

endpackage

// File: rtl/dpram_if.sv
// Port bundle for dpram_param: two independent access ports plus status.
// Handshake: an access is taken on any rising edge with en=1 while ready=1 (no
// per-access back-pressure); valid pulses for exactly one cycle, 1+OUT_REG
// cycles after that edge, and dout holds its value whenever valid is 0.
interface dpram_if #(
   parameter int DATA_W = 18,
   parameter int ADDR_W = 7
);
   logic              ena;
   logic              wea;
   logic [ADDR_W-1:0] addra;
   logic [DATA_W-1:0] dina;
   logic [DATA_W-1:0] douta;
   logic              valida;

   logic              enb;
   logic              web;
   logic [ADDR_W-1:0] addrb;
   logic [DATA_W-1:0] dinb;
   logic [DATA_W-1:0] doutb;
   logic              validb;

   logic              ready;
   logic              collision;

   modport master (
      output ena, wea, addra, dina, enb, web, addrb, dinb,
      input  douta, valida, doutb, validb, ready, collision
   );

   modport slave (
      input  ena, wea, addra, dina, enb, web, addrb, dinb,
      output douta, valida, doutb, validb, ready, collision
   );
endinterface

// File: rtl/dpram_core.sv
// Storage array with two read/write ports, read-during-write muxing and
// port-A priority on same-address writes. The array itself has no reset.
module dpram_core
   import dpram_pkg::*;
#(
   parameter int DATA_W   = 18,
   parameter int ADDR_W   = 7,
   parameter int DEPTH    = 128,
   parameter int RDW_MODE = 0
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              rea,
   input  logic              wea,
   input  logic [ADDR_W-1:0] addra,
   input  logic [DATA_W-1:0] dina,
   input  logic              reb,
   input  logic              web,
   input  logic [ADDR_W-1:0] addrb,
   input  logic [DATA_W-1:0] dinb,
   output logic [DATA_W-1:0] qa,
   output logic [DATA_W-1:0] qb
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic              same_addr;
   logic              web_eff;
   logic [DATA_W-1:0] rda;
   logic [DATA_W-1:0] rdb;

   assign same_addr = (addra == addrb);
   // Port B loses a same-address write to port A.
   assign web_eff   = web && !(wea && same_addr);

   always_comb begin
      rda = mem[addra];
      rdb = mem[addrb];
      if (RDW_MODE == RDW_NEW) begin
         if (wea)                       rda = dina;
         else if (web_eff && same_addr) rda = dinb;
         if (wea && same_addr)          rdb = dina;
         else if (web)                  rdb = dinb;
      end
   end

   always_ff @(posedge clock) begin
      if (wea)     mem[addra] <= dina;
      if (web_eff) mem[addrb] <= dinb;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         qa <= '0;
         qb <= '0;
      end else begin
         if (rea) qa <= rda;
         if (reb) qb <= rdb;
      end
   end

endmodule

// File: rtl/dpram_param.sv
// Parametrised true dual-port RAM: clear sequencer, address range checks,
// collision flag and optional output register around dpram_core.
module dpram_param
   import dpram_pkg::*;
#(
   parameter int DATA_W         = 18,
   parameter int ADDR_W         = 7,
   parameter int DEPTH          = 2 ** ADDR_W,
   parameter int RDW_MODE       = 0,
   parameter int OUT_REG        = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic       clock,
   input  logic       resetn,
   dpram_if.slave     bus,
   output logic [0:0] state_dbg
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

   if (DATA_W < 1 || DATA_W > 64 || DEPTH < 2 || clog2(DEPTH) > ADDR_W) begin : g_bad_params
      $error("dpram_param: illegal DATA_W / DEPTH / ADDR_W combination");
   end

   logic [0:0]        state;
   logic [ADDR_W-1:0] cnt;
   logic              rdy;
   logic              clearing;

   assign rdy      = (state == ST_READY);
   assign clearing = (state == ST_CLEAR) && (CLEAR_ON_RESET != 0);

   // Without clearing, CLEAR is a single pass-through cycle after reset.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state <= ST_CLEAR;
         cnt   <= '0;
      end else if (state == ST_CLEAR) begin
         if (CLEAR_ON_RESET == 0 || cnt == LAST_ADDR) state <= ST_READY;
         else                                         cnt   <= cnt + 1'b1;
      end
   end

   logic in_a, in_b;
   logic acc_a, acc_b;
   logic wr_a, wr_b;

   assign in_a  = ({1'b0, bus.addra} < DEPTH_EXT);
   assign in_b  = ({1'b0, bus.addrb} < DEPTH_EXT);
   assign acc_a = rdy && bus.ena;
   assign acc_b = rdy && bus.enb;
   assign wr_a  = acc_a && bus.wea && in_a;
   assign wr_b  = acc_b && bus.web && in_b;

   logic              core_wea;
   logic [ADDR_W-1:0] core_addra;
   logic [DATA_W-1:0] core_dina;
   logic [DATA_W-1:0] qa, qb;

   assign core_wea   = clearing || wr_a;
   assign core_addra = clearing ? cnt : bus.addra;
   assign core_dina  = clearing ? '0  : bus.dina;

   dpram_core #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .DEPTH    (DEPTH),
      .RDW_MODE (RDW_MODE)
   ) u_core (
      .clock  (clock),
      .resetn (resetn),
      .rea    (acc_a && in_a),
      .wea    (core_wea),
      .addra  (core_addra),
      .dina   (core_dina),
      .reb    (acc_b && in_b),
      .web    (wr_b),
      .addrb  (bus.addrb),
      .dinb   (bus.dinb),
      .qa     (qa),
      .qb     (qb)
   );

   logic              va1, vb1;
   logic              oob_a1, oob_b1;
   logic              coll_q;
   logic [DATA_W-1:0] da1, db1;

   // oob flags only move on an access, so a held dout stays held.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         va1    <= 1'b0;
         vb1    <= 1'b0;
         oob_a1 <= 1'b0;
         oob_b1 <= 1'b0;
         coll_q <= 1'b0;
      end else begin
         va1    <= acc_a;
         vb1    <= acc_b;
         if (acc_a) oob_a1 <= !in_a;
         if (acc_b) oob_b1 <= !in_b;
         coll_q <= wr_a && wr_b && (bus.addra == bus.addrb);
      end
   end

   assign da1 = oob_a1 ? '0 : qa;
   assign db1 = oob_b1 ? '0 : qb;

   if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_W-1:0] douta_q, doutb_q;
      logic              valida_q, validb_q;

      always_ff @(posedge clock or negedge resetn) begin
         if (!resetn) begin
            douta_q  <= '0;
            doutb_q  <= '0;
            valida_q <= 1'b0;
            validb_q <= 1'b0;
         end else begin
            valida_q <= va1;
            validb_q <= vb1;
            if (va1) douta_q <= da1;
            if (vb1) doutb_q <= db1;
         end
      end

      assign bus.douta  = douta_q;
      assign bus.doutb  = doutb_q;
      assign bus.valida = valida_q;
      assign bus.validb = validb_q;
   end else begin : g_no_out_reg
      assign bus.douta  = da1;
      assign bus.doutb  = db1;
      assign bus.valida = va1;
      assign bus.validb = vb1;
   end

   assign bus.ready     = rdy;
   assign bus.collision = coll_q;
   assign state_dbg     = state;

endmodule

// File: tb/tb_dpram_param.sv
// Bench for dpram_param: two instances (128 words / old-data / no out reg and
// 100 words / new-data / out reg) share one stimulus stream and a scoreboard.
module tb_dpram_param;
   import dpram_pkg::*;

   localparam int DATA_W  = 18;
   localparam int ADDR_W  = 7;
   localparam int DEPTH_0 = 128;
   localparam int DEPTH_1 = 100;

   // ---------------- clock / reset ----------------
   logic clock  = 1'b0;
   logic resetn = 1'b0;
   always #5 clock = ~clock;

   // ---------------- DUTs ----------------
   logic              ena, wea, enb, web;
   logic [ADDR_W-1:0] addra, addrb;
   logic [DATA_W-1:0] dina, dinb;
   logic [0:0]        state_dbg0, state_dbg1;

   dpram_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus0 ();
   dpram_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus1 ();

   assign bus0.ena = ena;   assign bus1.ena = ena;
   assign bus0.wea = wea;   assign bus1.wea = wea;
   assign bus0.addra = addra; assign bus1.addra = addra;
   assign bus0.dina = dina; assign bus1.dina = dina;
   assign bus0.enb = enb;   assign bus1.enb = enb;
   assign bus0.web = web;   assign bus1.web = web;
   assign bus0.addrb = addrb; assign bus1.addrb = addrb;
   assign bus0.dinb = dinb; assign bus1.dinb = dinb;

   dpram_param #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH_0),
      .RDW_MODE(RDW_OLD), .OUT_REG(0), .CLEAR_ON_RESET(1)
   ) u_dut0 (
      .clock(clock), .resetn(resetn), .bus(bus0), .state_dbg(state_dbg0)
   );

   dpram_param #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH_1),
      .RDW_MODE(RDW_NEW), .OUT_REG(1), .CLEAR_ON_RESET(1)
   ) u_dut1 (
      .clock(clock), .resetn(resetn), .bus(bus1), .state_dbg(state_dbg1)
   );

   logic              obs_v   [4];
   logic [DATA_W-1:0] obs_d   [4];
   logic              obs_rdy [2];
   logic              obs_coll[2];
   logic              obs_st  [2];

   assign obs_v[0] = bus0.valida; assign obs_d[0] = bus0.douta;
   assign obs_v[1] = bus0.validb; assign obs_d[1] = bus0.doutb;
   assign obs_v[2] = bus1.valida; assign obs_d[2] = bus1.douta;
   assign obs_v[3] = bus1.validb; assign obs_d[3] = bus1.doutb;
   assign obs_rdy[0]  = bus0.ready;     assign obs_rdy[1]  = bus1.ready;
   assign obs_coll[0] = bus0.collision; assign obs_coll[1] = bus1.collision;
   assign obs_st[0]   = state_dbg0[0];  assign obs_st[1]   = state_dbg1[0];

   // ---------------- model + scoreboard ----------------
   typedef struct {
      int                s;
      int                t;
      logic [DATA_W-1:0] d;
   } exp_t;

   exp_t              exp_q[$];
   int                depth_p [2];
   bit                rdw_p   [2];
   int                oreg_p  [2];
   logic [DATA_W-1:0] mem_m   [2][128];
   bit                rdy_m   [2];
   int                clr_m   [2];
   int                coll_at [2];
   logic [DATA_W-1:0] last_d  [4];
   int                cyc;
   int                n_cmp;
   int                n_err;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   // Applies one rising edge to the reference model of each instance.
   task automatic model_edge();
      bit                in_a, in_b, w_a, w_b, same;
      logic [DATA_W-1:0] old_a, old_b, res_a, res_b;
      exp_t              e;
      for (int d = 0; d < 2; d++) begin
         if (resetn) begin
            if (!rdy_m[d]) begin
               mem_m[d][clr_m[d]] = '0;
               if (clr_m[d] == depth_p[d] - 1) rdy_m[d] = 1'b1;
               else                            clr_m[d]++;
            end else begin
               in_a  = int'(addra) < depth_p[d];
               in_b  = int'(addrb) < depth_p[d];
               same  = (addra == addrb);
               old_a = in_a ? mem_m[d][addra] : '0;
               old_b = in_b ? mem_m[d][addrb] : '0;
               w_a   = ena && wea && in_a;
               w_b   = enb && web && in_b && !(w_a && same);

               if (!in_a)                          res_a = '0;
               else if (wea)                       res_a = rdw_p[d] ? dina : old_a;
               else if (rdw_p[d] && w_b && same)   res_a = dinb;
               else                                res_a = old_a;

               if (!in_b)                          res_b = '0;
               else if (rdw_p[d] && w_a && same)   res_b = dina;
               else if (web)                       res_b = rdw_p[d] ? dinb : old_b;
               else                                res_b = old_b;

               if (ena) begin
                  e.s = d * 2; e.t = cyc + oreg_p[d]; e.d = res_a;
                  exp_q.push_back(e);
               end
               if (enb) begin
                  e.s = d * 2 + 1; e.t = cyc + oreg_p[d]; e.d = res_b;
                  exp_q.push_back(e);
               end
               if (w_a && enb && web && in_b && same) coll_at[d] = cyc;
               if (w_a) mem_m[d][addra] = dina;
               if (w_b) mem_m[d][addrb] = dinb;
            end
         end
      end
   endtask

   always @(negedge clock) begin
      int    idx;
      string pn;
      for (int d = 0; d < 2; d++) begin
         check_eq($sformatf("ready%0d", d), 32'(obs_rdy[d]), 32'(rdy_m[d]));
         check_eq($sformatf("state%0d", d), 32'(obs_st[d]), 32'(rdy_m[d] ? ST_READY : ST_CLEAR));
         check_eq($sformatf("collision%0d", d), 32'(obs_coll[d]), 32'(coll_at[d] == cyc));
      end
      for (int s = 0; s < 4; s++) begin
         pn  = $sformatf("dut%0d_%s", s / 2, (s % 2) ? "b" : "a");
         idx = -1;
         for (int i = 0; i < exp_q.size(); i++)
            if (exp_q[i].s == s && exp_q[i].t == cyc) idx = i;
         if (idx >= 0) begin
            check_eq({pn, "_valid"}, 32'(obs_v[s]), 32'd1);
            check_eq({pn, "_dout"}, 32'(obs_d[s]), 32'(exp_q[idx].d));
            last_d[s] = exp_q[idx].d;
            exp_q.delete(idx);
         end else begin
            check_eq({pn, "_valid_idle"}, 32'(obs_v[s]), 32'd0);
            check_eq({pn, "_dout_hold"}, 32'(obs_d[s]), 32'(last_d[s]));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step(input bit ea, input bit wa, input int aa, input logic [DATA_W-1:0] da,
                       input bit eb, input bit wb, input int ab, input logic [DATA_W-1:0] db);
      ena = ea; wea = wa; addra = ADDR_W'(aa); dina = da;
      enb = eb; web = wb; addrb = ADDR_W'(ab); dinb = db;
      @(posedge clock);
      cyc++;
      model_edge();
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, 0, 0, '0);
   endtask

   task automatic apply_reset(input int n);
      resetn = 1'b0;
      exp_q.delete();
      for (int d = 0; d < 2; d++) begin
         rdy_m[d] = 1'b0; clr_m[d] = 0; coll_at[d] = -1;
      end
      for (int s = 0; s < 4; s++) last_d[s] = '0;
      idle(n);
      resetn = 1'b1;
   endtask

   task automatic rand_step();
      step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, pick_addr(), DATA_W'($urandom),
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, pick_addr(), DATA_W'($urandom));
   endtask

   function automatic int pick_addr();
      if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 7));
      return int'($urandom_range(96, 127));
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      cyc = 0; n_cmp = 0; n_err = 0;
      depth_p = '{DEPTH_0, DEPTH_1};
      rdw_p   = '{1'b0, 1'b1};
      oreg_p  = '{0, 1};
      for (int d = 0; d < 2; d++)
         for (int a = 0; a < 128; a++) mem_m[d][a] = '0;
      ena = 0; wea = 0; addra = '0; dina = '0;
      enb = 0; web = 0; addrb = '0; dinb = '0;

      apply_reset(3);
      // Abort the clear at count 60; writes meanwhile must be ignored.
      for (int i = 0; i < 60; i++)
         step(1, 1, $urandom_range(0, 127), DATA_W'($urandom), 1, 1, $urandom_range(0, 127), DATA_W'($urandom));
      apply_reset(2);
      for (int i = 0; i < 95; i++)
         step(1, 1, $urandom_range(0, 127), DATA_W'($urandom), 1, 1, $urandom_range(0, 127), DATA_W'($urandom));
      idle(DEPTH_0 - 95);

      for (int a = 0; a < 128; a++) step(0, 0, 0, '0, 1, 0, a, '0);
      idle(3);

      step(1, 1, 5, 18'h2A5A5, 0, 0, 0, '0);
      step(0, 0, 0, '0, 1, 0, 5, '0);
      idle(3);

      step(1, 1, 9, 18'h00011, 0, 0, 0, '0);
      step(1, 1, 9, 18'h3FFFF, 1, 0, 9, '0);
      step(1, 0, 9, '0, 0, 0, 0, '0);
      idle(3);

      step(0, 0, 0, '0, 1, 1, 12, 18'h0F0F0);
      step(1, 0, 12, '0, 1, 1, 12, 18'h12345);
      idle(3);

      step(1, 1, 3, 18'h00001, 1, 1, 3, 18'h00002);
      step(1, 0, 3, '0, 1, 0, 3, '0);
      idle(3);

      step(1, 1, 110, 18'h15555, 0, 0, 0, '0);
      step(0, 0, 0, '0, 1, 0, 110, '0);
      step(1, 1, 99, 18'h0ABCD, 1, 1, 110, 18'h2FFFF);
      step(1, 0, 110, '0, 1, 0, 99, '0);
      idle(3);

      for (int i = 0; i < 400; i++) rand_step();
      idle(4);
      check_eq("drain", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule
